// File: rtl/m_imm_gen_pipe.sv
// Purpose : pipelined immediate generator; decodes format from the opcode, sign-extends the
//           immediate to XLEN and computes pc + imm, then holds results in a two-entry skid buffer.
// Latency : 1 cycle (entry accepted at edge N is visible with o_valid=1 after edge N).
// Backpr. : valid/ready; o_in_ready is registered (= SKID empty), no comb path i_ready->o_in_ready.
// Ports   : w_clk/w_rst_n (sync active-low), i_valid/o_in_ready/i_ir/i_pc upstream,
//           i_flush drops everything, o_valid/i_ready/o_ir/o_imm/o_fmt/o_target downstream.
module m_imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            i_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_ir,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_ir,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic [XLEN-1:0] o_target
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [31:0]     ir;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] tgt;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

  // ---------------- input-side decode ----------------
  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  ent_t            w_new;

  always_comb begin
    w_fmt = FMT_NONE;
    case (i_ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: w_fmt = FMT_I;
      7'b0011011:                         w_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;  // OP-IMM-32
      7'b0100011:                         w_fmt = FMT_S;
      7'b1100011:                         w_fmt = FMT_B;
      7'b0110111, 7'b0010111:             w_fmt = FMT_U;
      7'b1101111:                         w_fmt = FMT_J;
      7'b1110011:                         w_fmt = i_ir[14] ? FMT_Z : FMT_NONE;     // CSR immediate forms
      default:                            w_fmt = FMT_NONE;
    endcase
  end

  // 32-bit immediate; every signed format already carries ir[31] in bit 31,
  // and Z leaves bit 31 clear, so one sign extension serves all formats.
  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
      FMT_S:   w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      FMT_B:   w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      FMT_U:   w_imm32 = {i_ir[31:12], 12'd0};
      FMT_J:   w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      FMT_Z:   w_imm32 = {27'd0, i_ir[19:15]};
      default: w_imm32 = 32'd0;
    endcase
  end

  if (XLEN == 64) begin : g_ext64
    assign w_imm = {{32{w_imm32[31]}}, w_imm32};
  end else begin : g_ext32
    assign w_imm = w_imm32;
  end

  assign w_new.ir  = i_ir;
  assign w_new.imm = w_imm;
  assign w_new.fmt = w_fmt;
  assign w_new.tgt = i_pc + w_imm;  // wraps mod 2^XLEN

  // ---------------- skid buffer control ----------------
  state_t r_state;
  state_t w_state_nxt;
  logic   r_in_ready;
  ent_t   r_main;
  ent_t   r_skid;
  logic   w_acc;
  logic   w_deq;
  logic   w_ld_main_new;
  logic   w_ld_main_skid;
  logic   w_ld_skid;

  assign w_acc = i_valid & r_in_ready;
  assign w_deq = (r_state != S_EMPTY) & i_ready;

  // state register
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_acc && !w_deq)      w_state_nxt = S_FULL;
          else if (!w_acc && w_deq) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_deq) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // output / load-enable logic
  always_comb begin
    o_valid        = (r_state != S_EMPTY);
    w_ld_main_new  = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (!i_flush) begin
      case (r_state)
        S_EMPTY: w_ld_main_new = w_acc;
        S_ONE: begin
          w_ld_main_new = w_acc & w_deq;
          w_ld_skid     = w_acc & ~w_deq;
        end
        S_FULL:  w_ld_main_skid = w_deq;
        default: ;
      endcase
    end
  end

  // data registers hold their value while invalid
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_new)       r_main <= w_new;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= w_new;
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_ir       = r_main.ir;
  assign o_imm      = r_main.imm;
  assign o_fmt      = r_main.fmt;
  assign o_target   = r_main.tgt;

endmodule

// File: tb/tb_m_imm_gen_pipe.sv
module tb_m_imm_gen_pipe;

  typedef struct {
    bit          is64;
    logic [31:0] ir;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
  } exp_t;

  localparam int NV = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v32, rdy32, fl32, ov32, ordy32;
  logic [31:0] ir32, pc32, oir32, oimm32, otgt32;
  logic [2:0]  ofmt32;

  logic        v64, rdy64, fl64, ov64, ordy64;
  logic [31:0] ir64, oir64;
  logic [63:0] pc64, oimm64, otgt64;
  logic [2:0]  ofmt64;

  m_imm_gen_pipe #(.XLEN(32)) u32 (
    .w_clk(clk), .w_rst_n(rst_n), .i_valid(v32), .o_in_ready(ordy32), .i_ir(ir32), .i_pc(pc32),
    .i_flush(fl32), .o_valid(ov32), .i_ready(rdy32), .o_ir(oir32), .o_imm(oimm32), .o_fmt(ofmt32),
    .o_target(otgt32)
  );

  m_imm_gen_pipe #(.XLEN(64)) u64 (
    .w_clk(clk), .w_rst_n(rst_n), .i_valid(v64), .o_in_ready(ordy64), .i_ir(ir64), .i_pc(pc64),
    .i_flush(fl64), .o_valid(ov64), .i_ready(rdy64), .o_ir(oir64), .o_imm(oimm64), .o_fmt(ofmt64),
    .o_target(otgt64)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [NV];
  exp_t q32[$];
  exp_t q64[$];
  exp_t cur32, cur64, e32, e64;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // Scoreboards: compare whatever is about to be dequeued, then record what is about to be accepted.
  always @(negedge clk) begin
    if (!rst_n || fl32) begin
      q32.delete();
    end else begin
      if (ov32 && rdy32) begin
        if (q32.size() == 0) begin
          chk("u32 unexpected output ir", 64'(oir32), 64'hDEAD_0000_0000_0000);
        end else begin
          e32 = q32.pop_front();
          chk("u32 ir", 64'(oir32), 64'(e32.ir));
          chk("u32 fmt", 64'(ofmt32), 64'(e32.fmt));
          chk("u32 imm", 64'(oimm32), e32.imm);
          chk("u32 target", 64'(otgt32), e32.tgt);
        end
      end
      if (v32 && ordy32) q32.push_back(cur32);
    end
  end

  always @(negedge clk) begin
    if (!rst_n || fl64) begin
      q64.delete();
    end else begin
      if (ov64 && rdy64) begin
        if (q64.size() == 0) begin
          chk("u64 unexpected output ir", 64'(oir64), 64'hDEAD_0000_0000_0000);
        end else begin
          e64 = q64.pop_front();
          chk("u64 ir", 64'(oir64), 64'(e64.ir));
          chk("u64 fmt", 64'(ofmt64), 64'(e64.fmt));
          chk("u64 imm", oimm64, e64.imm);
          chk("u64 target", otgt64, e64.tgt);
        end
      end
      if (v64 && ordy64) q64.push_back(cur64);
    end
  end

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.ir  = v.ir;
    e.fmt = v.fmt;
    e.imm = v.imm;
    e.tgt = v.tgt;
    return e;
  endfunction

  task automatic put32(input vec_t v);
    ir32  = v.ir;
    pc32  = v.pc[31:0];
    cur32 = to_exp(v);
    v32   = 1'b1;
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input vec_t v);
    int n;
    if (v.is64) begin
      ir64 = v.ir; pc64 = v.pc; cur64 = to_exp(v); v64 = 1'b1;
    end else begin
      put32(v);
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (v.is64 ? ordy64 : ordy32) break;
      n++;
      if (n > 50) begin
        chk("accept timeout o_in_ready", 64'(v.is64 ? ordy64 : ordy32), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain leftover entries", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  task automatic chk_rst32(input string tag);
    chk({tag, " o_valid"}, 64'(ov32), 64'd0);
    chk({tag, " o_in_ready"}, 64'(ordy32), 64'd1);
    chk({tag, " o_ir"}, 64'(oir32), 64'd0);
    chk({tag, " o_imm"}, 64'(oimm32), 64'd0);
    chk({tag, " o_fmt"}, 64'(ofmt32), 64'd0);
    chk({tag, " o_target"}, 64'(otgt32), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    v32 = 1'b0; rdy32 = 1'b1; fl32 = 1'b0; ir32 = '0; pc32 = '0;
    v64 = 1'b0; rdy64 = 1'b1; fl64 = 1'b0; ir64 = '0; pc64 = '0;
    cur32 = '{default: '0}; cur64 = '{default: '0};

    //          is64  ir            pc                     fmt   imm                    target
    tbl[0]  = '{1'b0, 32'hFFF00093, 64'h1000,              3'd1, 64'hFFFFFFFF,          64'h00000FFF};
    tbl[1]  = '{1'b0, 32'hFE112E23, 64'h1000,              3'd2, 64'hFFFFFFFC,          64'h00000FFC};
    tbl[2]  = '{1'b0, 32'h001000EF, 64'h1000,              3'd5, 64'h00000800,          64'h00001800};
    tbl[3]  = '{1'b0, 32'h300FD073, 64'h1000,              3'd6, 64'h0000001F,          64'h0000101F};
    tbl[4]  = '{1'b0, 32'h00000033, 64'h1000,              3'd0, 64'h0,                 64'h00001000};
    tbl[5]  = '{1'b0, 32'h00001097, 64'hFFFFF000,          3'd4, 64'h00001000,          64'h00000000};
    tbl[6]  = '{1'b0, 32'hFE000EE3, 64'h1000,              3'd3, 64'hFFFFFFFC,          64'h00000FFC};
    tbl[7]  = '{1'b0, 32'h0010009B, 64'h1000,              3'd0, 64'h0,                 64'h00001000};
    tbl[8]  = '{1'b0, 32'h800000B7, 64'h1000,              3'd4, 64'h80000000,          64'h80001000};
    tbl[9]  = '{1'b1, 32'h800000B7, 64'h1000,              3'd4, 64'hFFFFFFFF80000000,  64'hFFFFFFFF80001000};
    tbl[10] = '{1'b1, 32'h0010009B, 64'h1000,              3'd1, 64'h1,                 64'h1001};
    tbl[11] = '{1'b1, 32'hFFF00093, 64'h1000,              3'd1, 64'hFFFFFFFFFFFFFFFF,  64'h0FFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst32("reset");
    chk("reset u64 o_valid", 64'(ov64), 64'd0);
    chk("reset u64 o_in_ready", 64'(ordy64), 64'd1);
    chk("reset u64 o_imm", oimm64, 64'd0);
    chk("reset u64 o_target", otgt64, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // decode table, back-to-back with i_ready=1
    for (int i = 0; i < NV; i++) send(tbl[i]);
    drain();

    // backpressure: A, B accepted, C held upstream, then released
    rdy32 = 1'b0;
    @(posedge clk); #1;
    put32(tbl[0]); @(posedge clk); #1;
    put32(tbl[1]); @(posedge clk); #1;
    put32(tbl[2]);
    @(negedge clk);
    chk("bp in_ready after skid fill", 64'(ordy32), 64'd0);
    chk("bp o_valid", 64'(ov32), 64'd1);
    chk("bp main holds A", 64'(oir32), 64'(tbl[0].ir));
    repeat (2) begin
      @(negedge clk);
      chk("bp stalled ir stable", 64'(oir32), 64'(tbl[0].ir));
      chk("bp stalled imm stable", 64'(oimm32), tbl[0].imm);
      chk("bp stalled in_ready", 64'(ordy32), 64'd0);
    end
    @(posedge clk); #1;
    rdy32 = 1'b1;
    @(negedge clk);
    chk("bp release out A", 64'(oir32), 64'(tbl[0].ir));
    chk("bp in_ready while B in skid", 64'(ordy32), 64'd0);
    @(negedge clk);
    chk("bp release out B", 64'(oir32), 64'(tbl[1].ir));
    chk("bp in_ready after skid drains", 64'(ordy32), 64'd1);
    @(posedge clk); #1;
    v32 = 1'b0;
    @(negedge clk);
    chk("bp release out C", 64'(oir32), 64'(tbl[2].ir));
    chk("bp C valid", 64'(ov32), 64'd1);
    @(negedge clk);
    chk("bp empty after C", 64'(ov32), 64'd0);

    // flush while FULL with C on the input
    rdy32 = 1'b0;
    @(posedge clk); #1; put32(tbl[3]);
    @(posedge clk); #1; put32(tbl[6]);
    @(posedge clk); #1; put32(tbl[8]); fl32 = 1'b1;
    @(posedge clk); #1; fl32 = 1'b0; v32 = 1'b0;
    @(negedge clk);
    chk("flush full o_valid", 64'(ov32), 64'd0);
    chk("flush full o_in_ready", 64'(ordy32), 64'd1);
    rdy32 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush full nothing reappears", 64'(ov32), 64'd0);
    end

    // flush while EMPTY drops the input even though o_in_ready=1
    @(posedge clk); #1; put32(tbl[2]); fl32 = 1'b1;
    @(posedge clk); #1; fl32 = 1'b0; v32 = 1'b0;
    @(negedge clk);
    chk("flush empty drops input", 64'(ov32), 64'd0);

    // reset mid-stream while ONE, then fresh instruction latency
    rdy32 = 1'b0;
    @(posedge clk); #1; put32(tbl[4]);
    @(posedge clk); #1; v32 = 1'b0;
    @(negedge clk);
    chk("pre-reset o_valid", 64'(ov32), 64'd1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk_rst32("mid reset");
    rdy32 = 1'b1;
    @(posedge clk); #1; put32(tbl[5]);
    @(posedge clk); #1; v32 = 1'b0;
    @(negedge clk);
    chk("post-reset latency o_valid", 64'(ov32), 64'd1);
    chk("post-reset latency o_ir", 64'(oir32), 64'(tbl[5].ir));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/m_imm_gen_pipe.md
# m_imm_gen_pipe

Parametrised, pipelined successor to the combinational immediate generator. Decodes the immediate format directly from the opcode and sign-extends the immediate to XLEN. It adds a two-entry valid/ready skid buffer, a PC-relative target adder and a flush input, so it can sit as a registered stage between instruction fetch and the execute/branch unit.

## Interface
- XLEN, default 32: datapath width; legal values 32 or 64.
- w_clk  input  1  clock; all state changes on the rising edge.
- w_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  upstream has an instruction.
- o_in_ready  output  1  stage can accept; a transfer happens when i_valid & o_in_ready.
- i_ir  input  32  instruction word.
- i_pc  input  XLEN  PC of i_ir.
- i_flush  input  1  discard all held and incoming entries.
- o_valid  output  1  output entry valid.
- i_ready  input  1  downstream accepts; a transfer happens when o_valid & i_ready.
- o_ir  output  32  instruction of the output entry.
- o_imm  output  XLEN  decoded immediate.
- o_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- o_target  output  XLEN  (pc + o_imm) mod 2^XLEN.

## Operation
- Format decode from ir[6:0]:
  - 0000011, 0010011, 1100111 → I.
  - 0011011 → I only when XLEN=64; NONE otherwise.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 1110011 with ir[14]=1 → Z.
  - Any other opcode → NONE.
- Immediate bit fields:
  - I: ir[31:20].
  - S: {ir[31:25], ir[11:7]}.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U: {ir[31:12], 12'b0}.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - Z: zero-extended ir[19:15].
  - NONE: 0.
- Extension: I/S/B/U/J are sign-extended from ir[31] to XLEN. For XLEN=64, U is also sign-extended from bit 31.
- o_target is computed for every format with a wrapping XLEN-bit add and no overflow flag. The consumer decides whether to use it.
- Decode and add are performed on the input side; results are registered together with ir, pc-derived target and fmt.
- Buffer has two entries, MAIN (drives outputs) and SKID.
  - o_in_ready is a registered signal and equals !SKID.valid.
  - Order is strictly FIFO.
- States and transitions (acc = i_valid & o_in_ready, deq = o_valid & i_ready):
  - EMPTY:
    - acc → ONE, new entry into MAIN.
  - ONE:
    - acc & deq → ONE, MAIN replaced.
    - acc & !deq → FULL, new entry into SKID.
    - !acc & deq → EMPTY.
    - otherwise hold.
  - FULL:
    - deq → ONE, SKID moves to MAIN.
    - otherwise hold.
    - acc is impossible in FULL (o_in_ready=0).
- i_flush has priority over every transition: next state EMPTY, both entries invalidated, and any input presented in that cycle is dropped even if o_in_ready=1.
- Output data registers hold their last value while o_valid=0. Data values are only meaningful when o_valid=1.

## Timing
- Reset (w_rst_n=0 at a rising edge) values: o_valid=0, o_in_ready=1, o_ir=0, o_imm=0, o_fmt=0, o_target=0, state EMPTY.
- Reset asserted mid-operation discards all entries, identical to flush.
- Latency: an entry accepted at edge N appears with o_valid=1 after edge N; it can be dequeued at edge N+1.
- Throughput: one instruction per cycle while i_ready=1.
- o_in_ready falls one cycle after the SKID fill edge and rises one cycle after SKID drains.
- No combinational path from i_ready to o_in_ready, or from i_valid to o_valid.
- Outputs are stable while o_valid=1 and i_ready=0.
- After flush at edge N: o_valid=0 and o_in_ready=1 from edge N onward.

## Test plan
- XLEN=32 decode. Each instruction has pc=0x1000 and i_ready=1:
  - 0xFFF00093 → fmt 1, imm 0xFFFFFFFF, target 0x00000FFF.
  - 0xFE112E23 → fmt 2, imm 0xFFFFFFFC.
  - 0x001000EF → fmt 5, imm 0x00000800, target 0x00001800.
  - 0x300FD073 → fmt 6, imm 0x0000001F.
  - 0x00000033 → fmt 0, imm 0.
- XLEN=64 decode:
  - 0x800000B7 → fmt 4, imm 0xFFFFFFFF80000000.
  - 0x0010009B → fmt 1, imm 1.
  - At XLEN=32, 0x0010009B → fmt 0.
- Wrap: XLEN=32, pc=0xFFFFF000, ir=0x00001097 (AUIPC) → imm 0x00001000, target 0x00000000.
- Backpressure:
  - Setup: i_ready=0; present A, B, C on consecutive cycles.
  - Accepted: A then B. o_in_ready=0 after B is accepted, and C is held upstream.
  - Release: raise i_ready; outputs A, B, C on three consecutive cycles, with o_in_ready back to 1 one cycle after B leaves SKID.
- Flush in FULL: with A and B held and i_valid=1 carrying C, pulse i_flush one cycle → o_valid=0 next cycle. None of A, B or C ever appears. o_in_ready=1.
- Reset mid-stream: assert w_rst_n=0 for one edge while in ONE → all outputs reach their reset values. A fresh instruction accepted afterwards appears with 1-cycle latency.
